alu_iterative: RTL

Multi-cycle execute-stage ALU that consumes the 4-bit `Operation` code produced by the ALU controller and returns a registered `ALUResult` plus `Zero` flag. Logic, arithmetic, compare and branch-condition ops complete in one cycle. Shifts are performed iteratively, one bit per cycle, so no barrel shifter is needed. A start/busy/done handshake lets the pipeline stall on long shifts.

---
 rtl/alu_iterative.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alu_iterative.sv
// alu_iterative: execute-stage ALU. Logic/arith/compare ops finish in one
// cycle; shifts walk one bit per cycle through a shift register so there is
// no barrel shifter. start/busy/done lets the pipeline stall on long shifts.
module alu_iterative #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_BNE  = 4'b1010;
  localparam logic [3:0] OP_BGE  = 4'b1011;
  localparam logic [3:0] OP_BLT  = 4'b1111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, shnxt, res1c;
  logic [SHAMT_W-1:0]    cnt, n_in;
  logic [3:0]            shop;
  logic                  is_shift_in, accept, launch, finish;

  // Request decode: a shift with n>0 goes iterative, everything else is 1-cycle.
  always_comb begin
    n_in        = SrcB[SHAMT_W-1:0];
    is_shift_in = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
    accept      = (state == IDLE) && start;
    launch      = accept && is_shift_in && (n_in != '0);
    finish      = (state == SHIFT) && (cnt == SHAMT_W'(1));
    busy        = (state == SHIFT);
  end

  // Single-cycle result; a shift only lands here when n=0, so it passes A.
  always_comb begin
    res1c = '0;
    case (Operation)
      OP_AND:          res1c = SrcA & SrcB;
      OP_OR:           res1c = SrcA | SrcB;
      OP_ADD:          res1c = SrcA + SrcB;
      OP_XOR:          res1c = SrcA ^ SrcB;
      OP_SUB:          res1c = SrcA - SrcB;
      OP_SLT, OP_BLT:  res1c[0] = $signed(SrcA) < $signed(SrcB);
      OP_BEQ:          res1c[0] = SrcA == SrcB;
      OP_BNE:          res1c[0] = SrcA != SrcB;
      OP_BGE:          res1c[0] = $signed(SrcA) >= $signed(SrcB);
      OP_SLL, OP_SRL,
      OP_SRA:          res1c = SrcA;
      default:         res1c = '0;
    endcase
  end

  // One-bit step of the latched shift op.
  always_comb begin
    case (shop)
      OP_SLL:  shnxt = {shreg[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  shnxt = {1'b0, shreg[DATA_WIDTH-1:1]};
      default: shnxt = {shreg[DATA_WIDTH-1], shreg[DATA_WIDTH-1:1]};
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = SHIFT;
      SHIFT:   if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath: shift register, counter, registered result/flag and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      cnt       <= '0;
      shop      <= '0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && !launch) begin
        ALUResult <= res1c;
        Zero      <= (res1c == '0);
        done      <= 1'b1;
      end
      if (launch) begin
        shreg <= SrcA;
        cnt   <= n_in;
        shop  <= Operation;
      end
      if (state == SHIFT) begin
        shreg <= shnxt;
        cnt   <= cnt - SHAMT_W'(1);
        if (finish) begin
          ALUResult <= shnxt;
          Zero      <= (shnxt == '0);
          done      <= 1'b1;
        end
      end
    end
  end

endmodule
